// File: rtl/mod_148_timer_rand_bank_if.sv
// Control/status bundle for the random-duration timer bank.
// The master drives per-channel start/stop pulses; the slave (the timer bank)
// returns done/running status and the duration loaded at the last start.
interface mod_148_timer_rand_bank_if #(
  parameter int NUM_CH = 2,
  parameter int W_DUR  = 9
);
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       timer_done;
  logic [NUM_CH-1:0]       timer_not_done;
  logic [NUM_CH*W_DUR-1:0] load_dur;

  modport master (
    output start,
    output stop,
    input  timer_done,
    input  timer_not_done,
    input  load_dur
  );

  modport slave (
    input  start,
    input  stop,
    output timer_done,
    output timer_not_done,
    output load_dur
  );
endinterface

// File: rtl/mod_148_timer_rand_bank.sv
// Bank of NUM_CH independent start/stop timers with done/not_done status.
// Each start loads a duration drawn from a free-running 16-bit Galois LFSR,
// scaled into [DUR_MIN, DUR_MAX] time units (or DUR_MAX in fixed mode), and
// counts it down at CLKS_PER_UNIT clocks per unit.
module mod_148_timer_rand_bank #(
  parameter int          NUM_CH        = 2,
  parameter int          DUR_MIN       = 40,
  parameter int          DUR_MAX       = 295,
  parameter int          CLKS_PER_UNIT = 4,
  parameter int          RANDOM_MODE   = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic clk,
  input logic reset_n,
  mod_148_timer_rand_bank_if.slave bus
);

  localparam int W_DUR = $clog2(DUR_MAX + 1);
  // A single-cycle unit still needs a 1-bit prescaler that simply stays at 0.
  localparam int W_PRE = (CLKS_PER_UNIT > 1) ? $clog2(CLKS_PER_UNIT) : 1;

  localparam logic [W_PRE-1:0] PRE_LAST = W_PRE'(CLKS_PER_UNIT - 1);
  localparam logic [15:0]      SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [W_DUR-1:0] D_MIN    = W_DUR'(DUR_MIN);
  localparam logic [W_DUR-1:0] D_MAX    = W_DUR'(DUR_MAX);
  localparam logic [W_DUR-1:0] D_RANGE  = W_DUR'(DUR_MAX - DUR_MIN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;
  logic [31:0] lfsr_dbl;

  logic [NUM_CH-1:0]       done_vec;
  logic [NUM_CH-1:0]       run_vec;
  logic [NUM_CH*W_DUR-1:0] load_vec;

  // Right-shifting Galois step with taps x^16+x^14+x^13+x^11+1; a non-zero
  // seed can never reach the all-zero lock-up state.
  always_comb begin
    lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
  end

  // Free-running LFSR, advances every cycle out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_reg <= SEED_EFF;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  // Doubled copy so a left rotation becomes a constant part-select.
  assign lfsr_dbl = {lfsr_reg, lfsr_reg};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam int ROT = (3 * gi) % 16;

      logic [W_DUR-1:0] dur_draw;
      state_t           state_reg, state_next;
      logic [W_DUR-1:0] cnt_reg, cnt_next;
      logic [W_PRE-1:0] pre_reg, pre_next;
      logic [W_DUR-1:0] dur_reg, dur_next;

      if (RANDOM_MODE != 0) begin : g_rand
        logic [15:0]         rnd;
        logic [16+W_DUR-1:0] prod;
        logic                prod_lo_unused;

        // Each channel sees its own rotation, so simultaneous starts differ.
        assign rnd            = lfsr_dbl[31-ROT -: 16];
        // Scale a 16-bit fraction onto the range: floor(rnd*range / 2^16).
        assign prod           = {{W_DUR{1'b0}}, rnd} * {16'h0000, D_RANGE};
        assign dur_draw       = D_MIN + prod[16+W_DUR-1:16];
        assign prod_lo_unused = ^prod[15:0];
      end else begin : g_fixed
        assign dur_draw = D_MAX;
      end

      // Next-state logic: start beats stop, stop beats counting.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pre_next   = pre_reg;
        dur_next   = dur_reg;
        if (bus.start[gi]) begin
          state_next = ST_RUN;
          cnt_next   = dur_draw;
          pre_next   = '0;
          dur_next   = dur_draw;
        end else if (bus.stop[gi]) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          pre_next   = '0;
        end else if (state_reg == ST_RUN) begin
          if (pre_reg == PRE_LAST) begin
            pre_next = '0;
            cnt_next = cnt_reg - W_DUR'(1);
            if (cnt_reg == W_DUR'(1)) begin
              state_next = ST_DONE;
            end
          end else begin
            pre_next = pre_reg + W_PRE'(1);
          end
        end
      end

      // Channel state, counters and loaded duration.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          pre_reg   <= '0;
          dur_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          pre_reg   <= pre_next;
          dur_reg   <= dur_next;
        end
      end

      // Status is decoded from registered state only.
      assign done_vec[gi]                  = (state_reg == ST_DONE);
      assign run_vec[gi]                   = (state_reg == ST_RUN);
      assign load_vec[gi*W_DUR +: W_DUR]   = dur_reg;
    end
  endgenerate

  assign bus.timer_done     = done_vec;
  assign bus.timer_not_done = run_vec;
  assign bus.load_dur       = load_vec;

endmodule

// File: tb/tb_mod_148_timer_rand_bank.sv
// Self-checking bench for the random-duration timer bank.
// A reference model tracks each channel as "active until absolute edge E"
// and pushes the expected done event (duration, edge) into a per-channel
// queue; a negedge monitor compares status every cycle and pops the queue
// whenever a channel's done rises. A second instance in fixed mode is checked
// with directed timing sequences.
module tb_mod_148_timer_rand_bank;

  localparam int          NCH  = 2;
  localparam int          DMIN = 4;
  localparam int          DMAX = 7;
  localparam int          CPU  = 1;
  localparam int          WD   = 3;
  localparam logic [15:0] SEED = 16'h1234;

  localparam int FD_MAX = 5;
  localparam int FCPU   = 4;
  localparam int FWD    = 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  always #5 clk = ~clk;

  mod_148_timer_rand_bank_if #(.NUM_CH(NCH), .W_DUR(WD))  bus ();
  mod_148_timer_rand_bank_if #(.NUM_CH(NCH), .W_DUR(FWD)) fb ();

  mod_148_timer_rand_bank #(
    .NUM_CH(NCH), .DUR_MIN(DMIN), .DUR_MAX(DMAX), .CLKS_PER_UNIT(CPU),
    .RANDOM_MODE(1), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  mod_148_timer_rand_bank #(
    .NUM_CH(NCH), .DUR_MIN(2), .DUR_MAX(FD_MAX), .CLKS_PER_UNIT(FCPU),
    .RANDOM_MODE(0), .LFSR_SEED(16'h0000)
  ) dut_fixed (
    .clk(clk), .reset_n(reset_n), .bus(fb)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int dur;
    int done_edge;
  } exp_t;

  logic [15:0] m_lfsr = SEED;
  bit          m_active[NCH];
  int          m_end[NCH];
  int          m_dur[NCH];
  int          edge_no = 0;
  exp_t        sb_q[NCH][$];
  bit          seen[8];
  logic [NCH-1:0] prev_done = '0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Duration drawn for channel ch from LFSR value l: rotate left by 3*ch,
  // then scale the 16-bit fraction into [DMIN, DMAX].
  function automatic int draw(input logic [15:0] l, input int ch);
    int          s;
    logic [31:0] r;
    s = (3 * ch) % 16;
    r = ((32'(l) << s) | (32'(l) >> (16 - s))) & 32'h0000_FFFF;
    return DMIN + int'((r * 32'(DMAX - DMIN + 1)) >> 16);
  endfunction

  // Model update on every active edge; reset is asynchronous like the DUT.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_lfsr <= SEED;
      for (int c = 0; c < NCH; c++) begin
        m_active[c] <= 1'b0;
        m_dur[c]    <= 0;
        sb_q[c].delete();
      end
    end else begin
      edge_no <= edge_no + 1;
      for (int c = 0; c < NCH; c++) begin
        if (bus.start[c] || bus.stop[c]) begin
          // A run still in progress is aborted: its done event never comes.
          if (m_active[c] && (edge_no + 1) <= m_end[c] && sb_q[c].size() > 0)
            void'(sb_q[c].pop_back());
          if (bus.start[c]) begin
            m_dur[c]    <= draw(m_lfsr, c);
            m_active[c] <= 1'b1;
            m_end[c]    <= edge_no + 1 + draw(m_lfsr, c) * CPU;
            sb_q[c].push_back('{draw(m_lfsr, c), edge_no + 1 + draw(m_lfsr, c) * CPU});
          end else begin
            m_active[c] <= 1'b0;
          end
        end
      end
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  function automatic logic [9:0] exp_vec();
    logic [9:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      v[8+c]       = m_active[c] && (edge_no >= m_end[c]);
      v[6+c]       = m_active[c] && (edge_no < m_end[c]);
      v[c*3 +: 3]  = 3'(m_dur[c]);
    end
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("status", {bus.timer_done, bus.timer_not_done, bus.load_dur}, exp_vec());
      for (int c = 0; c < NCH; c++) begin
        if (bus.timer_done[c] && !prev_done[c]) begin
          if (sb_q[c].size() == 0) begin
            check("done_expected", 32'(bus.timer_done[c]), 32'd0);
          end else begin
            check("done_edge", edge_no, sb_q[c][0].done_edge);
            check("done_dur", 32'(bus.load_dur[c*WD +: WD]), sb_q[c][0].dur);
            seen[bus.load_dur[c*WD +: WD]] <= 1'b1;
            void'(sb_q[c].pop_front());
          end
        end
      end
      prev_done <= bus.timer_done;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [1:0] st, input logic [1:0] sp);
    @(negedge clk);
    bus.start = st;
    bus.stop  = sp;
    $display("txn t=%0t start=%b stop=%b", $time, st, sp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.start = '0;
      bus.stop  = '0;
    end
  endtask

  // Fixed-mode run: optional restart after restart_after cycles, then expect
  // FD_MAX*FCPU running cycles, sticky done, and a clean stop.
  task automatic fixed_run(input int restart_after);
    @(negedge clk);
    fb.start = 2'b01;
    $display("txn t=%0t fixed start restart_after=%0d", $time, restart_after);
    @(negedge clk);
    fb.start = 2'b00;
    if (restart_after > 0) begin
      repeat (restart_after - 1) @(negedge clk);
      fb.start = 2'b01;
      @(negedge clk);
      fb.start = 2'b00;
    end
    for (int j = 0; j < FD_MAX * FCPU + 5; j++) begin
      check("fixed_run", {fb.timer_done, fb.timer_not_done, fb.load_dur},
            {1'b0, (j >= FD_MAX * FCPU), 1'b0, (j < FD_MAX * FCPU), 3'd0, 3'(FD_MAX)});
      @(negedge clk);
    end
    fb.stop = 2'b01;
    @(negedge clk);
    fb.stop = 2'b00;
    check("fixed_stop", {fb.timer_done, fb.timer_not_done, fb.load_dur},
          {4'b0000, 3'd0, 3'(FD_MAX)});
  endtask

  // ---------------- main sequence ----------------
  logic [1:0] st, sp;
  int         off, extra, k, nseen;

  initial begin
    bus.start = '0; bus.stop = '0;
    fb.start  = '0; fb.stop  = '0;
    reset_n   = 1'b0;
    @(posedge clk);
    #1 mon_en = 1'b1;

    // Reset held with start toggling: everything must stay quiet.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start = 2'(i % 2 ? 3 : 0);
      fb.start  = 2'(i % 2 ? 3 : 0);
    end
    @(negedge clk);
    bus.start = '0; fb.start = '0;
    check("reset_out", {bus.timer_done, bus.timer_not_done, bus.load_dur}, 32'd0);
    reset_n = 1'b1;
    idle(100);

    // Directed: restart at +5, stop while running, collision in DONE,
    // simultaneous starts, stop in IDLE.
    drive(2'b01, 2'b00); idle(4);
    drive(2'b01, 2'b00); idle(15);
    drive(2'b01, 2'b00); idle(2);
    drive(2'b00, 2'b01); idle(10);
    drive(2'b01, 2'b00); idle(12);
    drive(2'b01, 2'b01); idle(12);
    drive(2'b11, 2'b00); idle(12);
    drive(2'b00, 2'b11); idle(3);
    drive(2'b00, 2'b11); idle(3);

    // Fixed-mode timing, with a restart mid-prescale and a mid-run abort.
    fixed_run(0);
    fixed_run(7);
    @(negedge clk); fb.start = 2'b01;
    @(negedge clk); fb.start = 2'b00;
    repeat (6) @(negedge clk);
    fb.stop = 2'b01;
    @(negedge clk); fb.stop = 2'b00;
    check("fixed_abort", {fb.timer_done, fb.timer_not_done}, 32'd0);
    repeat (25) @(negedge clk);
    check("fixed_abort_quiet", {fb.timer_done, fb.timer_not_done}, 32'd0);

    // Mid-run asynchronous reset: outputs clear before the next clock edge.
    drive(2'b11, 2'b00); idle(2);
    #2 reset_n = 1'b0;
    #1 check("async_reset", {bus.timer_done, bus.timer_not_done, bus.load_dur}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(20);

    // Randomized traffic.
    for (int it = 0; it < 1000; it++) begin
      st  = 2'($urandom_range(1, 3));
      sp  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      drive(st, sp);
      off = $urandom_range(1, 10);
      idle(off);
      extra = 0;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 1);
        if ($urandom_range(0, 1) == 1) drive(2'b01 << k, 2'b00);
        else                          drive(2'b00, 2'b01 << k);
        extra = 1;
      end
      idle(19 - off - extra);
    end
    idle(30);

    nseen = 0;
    for (int v = DMIN; v <= DMAX; v++) nseen += int'(seen[v]);
    check("all_durations_seen", nseen, DMAX - DMIN + 1);
    for (int c = 0; c < NCH; c++) check("queue_drained", sb_q[c].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mod_148_timer_rand_bank.md
Name: mod_148_timer_rand_bank

Overview:
Synthesizable, parametrised successor to the simulation-only random-duration timer (wait_beacon_timer class). It provides NUM_CH independent IEEE 802.3-style timers, each with start/stop control and done/not_done status. Each timer loads a pseudo-random duration drawn uniformly from [DUR_MIN, DUR_MAX] time units, or a fixed DUR_MAX in fixed mode. It is instantiated by Clause 148 PLCA/beacon state machines in place of the `ifdef simulate model.

Parameters:
NUM_CH, 2, number of independent timer channels (1..16)
DUR_MIN, 40, minimum duration in time units (BT); must be >= 1
DUR_MAX, 295, maximum duration in time units; must be >= DUR_MIN
CLKS_PER_UNIT, 4, clk cycles per time unit; must be >= 1
RANDOM_MODE, 1, 1 = random duration per start; 0 = every start loads DUR_MAX
LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1

Ports:
clk  input  1  single clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  NUM_CH  per-channel start_timer pulse, sampled each cycle
stop  input  NUM_CH  per-channel abort; returns channel to IDLE
timer_done  output  NUM_CH  channel expired, held until next start or stop
timer_not_done  output  NUM_CH  channel running
load_dur  output  NUM_CH*W_DUR  duration loaded at last start, channel i at bits [i*W_DUR +: W_DUR]; W_DUR = $clog2(DUR_MAX+1)

Behaviour:
- Reset (reset_n low, asynchronous): all channels IDLE; timer_done=0, timer_not_done=0, load_dur=0, unit and prescale counters=0, LFSR=LFSR_SEED (or 16'hACE1 if the seed is 0).
- LFSR: 16-bit Galois, mask 16'hB400 (x^16+x^14+x^13+x^11+1). Shifts right every cycle after reset regardless of channel activity. It never reaches 0.
- Random draw for channel i in cycle k: r_i = LFSR rotated left by 3*i. D = DUR_MIN + ((r_i * (DUR_MAX-DUR_MIN+1)) >> 16). The computation is one cycle, pure combinational, and uses a product of 16 + W_DUR bits. D is always in [DUR_MIN, DUR_MAX].
- Fixed mode (RANDOM_MODE=0): D = DUR_MAX.
- Per-channel FSM states: IDLE, RUN, DONE.
  - IDLE: timer_done=0, timer_not_done=0.
  - RUN: timer_done=0, timer_not_done=1.
  - DONE: timer_done=1, timer_not_done=0.
- Start (start[i]=1 at edge k), from any state:
  - load unit counter = D and load_dur[i] = D;
  - clear the prescaler;
  - enter RUN, visible from cycle k+1.
- Counting in RUN:
  - prescaler counts 0..CLKS_PER_UNIT-1;
  - on wrap, unit counter decrements;
  - when the unit counter reaches 0, the channel enters DONE.
  - timer_not_done is high for exactly D*CLKS_PER_UNIT cycles, then timer_done rises.
- Restart: start while in RUN or DONE reloads a new D and restarts counting. No DONE pulse is produced for the aborted run.
- Stop (stop[i]=1) with start[i]=0: channel enters IDLE next cycle and the counters clear. load_dur holds its value.
- Simultaneous start and stop on the same channel: start wins (restart).
- Stop in IDLE has no effect.
- DONE is sticky until start or stop.
- Channels are fully independent. Simultaneous starts on different channels draw from differently rotated LFSR values in the same cycle.
- Outputs are registered; there is no combinational path from start/stop to any output.
- Reset asserted mid-run returns the channel to IDLE immediately (asynchronous); it restarts only on a new start after reset release.

Test Plan:
- Reset: hold reset_n=0 for 5 cycles with start toggling -> all timer_done/timer_not_done=0, load_dur=0. Release and stay idle 100 cycles -> outputs stay 0.
- Fixed mode: RANDOM_MODE=0, DUR_MAX=5, CLKS_PER_UNIT=4, start[0] pulse at cycle 10 -> timer_not_done[0]=1 for cycles 11..30, timer_done[0]=1 from cycle 31 and held until stop; channel 1 unaffected.
- Random range: DUR_MIN=4, DUR_MAX=7, CLKS_PER_UNIT=1, 1000 starts spaced 20 cycles apart -> every load_dur in [4,7], all four values observed, each run length equals load_dur. Values match a bench LFSR reference model bit-exactly.
- Restart and stop: start at cycle 0 then start again at cycle 5 -> timer_done never pulses before new D*CLKS_PER_UNIT cycles after cycle 5. Stop while RUN -> IDLE next cycle, no timer_done.
- Collision: start[0]=stop[0]=1 same cycle while in DONE -> RUN next cycle with new load_dur. Start[0] and start[1] same cycle -> independent durations per the rotation rule.
- Mid-run reset: assert reset_n=0 at D/2 -> outputs drop to 0 asynchronously, before the next clk edge. After release, no activity until start.
